// File: rtl/pkt_reader.sv
// rtl/pkt_reader.sv - read-side packet transmitter: drains RAM words as a sop/eop/val stream
// Output register plus a 2-entry skid buffer absorbs the in-flight RAM read under backpressure.
module pkt_reader #(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              start_i,
   input  logic [AWIDTH:0]   len_i,
   output logic [AWIDTH-1:0] rdpntr_o,
   input  logic [DWIDTH-1:0] q_i,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam int EW = DWIDTH + 2;
   localparam logic [AWIDTH:0]   MAX_LEN = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH-1:0] A_ONE   = {{(AWIDTH-1){1'b0}}, 1'b1};

   state_t            state, state_n;
   logic [AWIDTH-1:0] rdpntr_n;
   logic [AWIDTH-1:0] last, last_n;
   logic [AWIDTH-1:0] faddr, faddr_n;
   logic              fvld, fvld_n;
   logic [EW-1:0]     skid [2];
   logic [EW-1:0]     skid_n [2];
   logic [1:0]        scnt, scnt_n;
   logic [DWIDTH-1:0] data_n;
   logic              sop_n, eop_n, val_n;
   logic              xfer, issue, load;
   logic [2:0]        occ;
   logic [EW-1:0]     word_in;

   assign busy_o = (state != IDLE);

   always_comb begin
      state_n  = state;
      rdpntr_n = rdpntr_o;
      last_n   = last;
      faddr_n  = faddr;
      fvld_n   = 1'b0;
      skid_n   = skid;
      scnt_n   = scnt;
      data_n   = data_o;
      sop_n    = sop_o;
      eop_n    = eop_o;
      val_n    = val_o;
      issue    = 1'b0;
      xfer     = val_o && ready_i;
      load     = !val_o || xfer;
      occ      = {2'b00, val_o} + {1'b0, scnt} + {2'b00, fvld};
      word_in  = {faddr == '0, faddr == last, q_i};

      case (state)
         IDLE: begin
            if (start_i && len_i != '0) begin
               state_n  = READ;
               rdpntr_n = '0;
               // lower bits minus one wrap correctly for len == 2**AWIDTH
               last_n   = (len_i > MAX_LEN) ? '1 : (len_i[AWIDTH-1:0] - A_ONE);
            end
         end
         READ: begin
            // a read issued now lands two edges later; reserve its slot assuming no transfer next cycle
            issue = (occ <= (3'd2 + {2'b00, xfer}));
            if (issue) begin
               fvld_n  = 1'b1;
               faddr_n = rdpntr_o;
               if (rdpntr_o == last) state_n = DRAIN;
               else                  rdpntr_n = rdpntr_o + A_ONE;
            end
         end
         DRAIN: begin
            if (xfer && eop_o) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (load) begin
         if (scnt != 2'd0) begin
            {sop_n, eop_n, data_n} = skid[0];
            val_n     = 1'b1;
            skid_n[0] = skid[1];
            scnt_n    = scnt - 2'd1;
         end else if (fvld) begin
            {sop_n, eop_n, data_n} = word_in;
            val_n = 1'b1;
         end else begin
            val_n = 1'b0;
            sop_n = 1'b0;
            eop_n = 1'b0;
         end
      end

      if (fvld && !(load && scnt == 2'd0)) begin
         if (scnt_n == 2'd0) skid_n[0] = word_in;
         else                skid_n[1] = word_in;
         scnt_n = scnt_n + 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state    <= IDLE;
         rdpntr_o <= '0;
         last     <= '0;
         faddr    <= '0;
         fvld     <= 1'b0;
         skid[0]  <= '0;
         skid[1]  <= '0;
         scnt     <= 2'd0;
         data_o   <= '0;
         sop_o    <= 1'b0;
         eop_o    <= 1'b0;
         val_o    <= 1'b0;
      end else begin
         state    <= state_n;
         rdpntr_o <= rdpntr_n;
         last     <= last_n;
         faddr    <= faddr_n;
         fvld     <= fvld_n;
         skid     <= skid_n;
         scnt     <= scnt_n;
         data_o   <= data_n;
         sop_o    <= sop_n;
         eop_o    <= eop_n;
         val_o    <= val_n;
      end
   end
endmodule

// File: tb/tb_pkt_reader.sv
// tb/tb_pkt_reader.sv - randomized bench for pkt_reader with a queue-based packet model
// The model expands each accepted start into its expected word list and checks every transfer.
module tb_pkt_reader;
   localparam int AW = 3;
   localparam int DW = 8;
   localparam int NMAX = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          srst, start, ready;
   logic [AW:0]   len;
   logic [AW-1:0] rdpntr;
   logic [DW-1:0] q, data;
   logic          sop, eop, val, busy;
   logic [DW-1:0] mem [NMAX];

   pkt_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk_i(clk), .srst_i(srst), .start_i(start), .len_i(len), .rdpntr_o(rdpntr),
      .q_i(q), .ready_i(ready), .data_o(data), .sop_o(sop), .eop_o(eop), .val_o(val),
      .busy_o(busy)
   );

   always @(posedge clk) q <= mem[rdpntr];

   typedef struct packed {logic [DW-1:0] d; logic s; logic e;} word_t;
   word_t exp_q[$];
   word_t w_pop;

   int n_chk = 0, n_fail = 0;
   int first_cd = 0, xfer_cnt = 0, pkt_cnt = 0;
   bit arm = 0, chk_rst = 0, prev_stall = 0, exp_next = 0, m_busy = 0, b_was;
   logic [DW-1:0] p_data;
   logic p_sop, p_eop;
   int rmode = 0, rstep = 0, stall_left = 0, base = 0;
   bit pat [6] = '{1, 0, 0, 1, 0, 1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (arm) begin
         if (chk_rst) begin
            chk("rst_val", 32'(val), 0);  chk("rst_sop", 32'(sop), 0);
            chk("rst_eop", 32'(eop), 0);  chk("rst_busy", 32'(busy), 0);
            chk("rst_data", 32'(data), 0); chk("rst_rdpntr", 32'(rdpntr), 0);
            chk_rst = 0;
         end
         chk("busy", 32'(busy), 32'(m_busy));
         chk("val_without_expect", 32'(val && exp_q.size() == 0), 0);
         if (prev_stall) begin
            chk("hold_val", 32'(val), 1);   chk("hold_data", 32'(data), 32'(p_data));
            chk("hold_sop", 32'(sop), 32'(p_sop)); chk("hold_eop", 32'(eop), 32'(p_eop));
         end
         if (exp_next) chk("gap", 32'(val), 1);
         if (first_cd > 0) begin
            first_cd--;
            if (first_cd == 0) begin
               chk("lat_val", 32'(val), 1); chk("lat_sop", 32'(sop), 1);
            end else chk("early_val", 32'(val), 0);
         end
         exp_next = 0;
         if (srst) begin
            exp_q.delete();
            m_busy = 0; first_cd = 0; prev_stall = 0; chk_rst = 1;
         end else begin
            b_was = m_busy;
            if (val && ready && exp_q.size() > 0) begin
               w_pop = exp_q.pop_front();
               chk("data", 32'(data), 32'(w_pop.d));
               chk("sop", 32'(sop), 32'(w_pop.s));
               chk("eop", 32'(eop), 32'(w_pop.e));
               xfer_cnt++;
               exp_next = !w_pop.e;
               if (w_pop.e) m_busy = 0;
            end
            prev_stall = val && !ready;
            p_data = data; p_sop = sop; p_eop = eop;
            if (!b_was && start && len != 0) begin
               int l;
               l = (int'(len) > NMAX) ? NMAX : int'(len);
               for (int k = 0; k < l; k++) exp_q.push_back({mem[k], k == 0, k == l - 1});
               m_busy = 1; first_cd = 3; pkt_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_ready();
      case (rmode)
         0: ready = 1'b1;
         1: ready = pat[rstep % 6];
         2: ready = 1'($urandom_range(0, 1));
         default: begin
            if (xfer_cnt - base == 2 && stall_left > 0) begin ready = 1'b0; stall_left--; end
            else ready = 1'b1;
         end
      endcase
      rstep++;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((m_busy || exp_q.size() != 0) && n < budget) begin set_ready(); tick(); n++; end
      chk("timeout", 32'(m_busy || exp_q.size() != 0), 0);
      ready = 1'b1;
   endtask

   task automatic send(input int l, input int mode);
      int eff;
      eff = (l > NMAX) ? NMAX : l;
      rmode = mode; rstep = 0; stall_left = 5; base = xfer_cnt;
      start = 1'b1; len = (AW+1)'(l); set_ready(); tick();
      start = 1'b0;
      wait_done(300);
      chk("word_count", 32'(xfer_cnt - base), 32'(eff));
   endtask

   initial begin
      int b, n;
      srst = 1'b1; start = 1'b0; len = '0; ready = 1'b1;
      for (int k = 0; k < NMAX; k++) mem[k] = '0;
      tick(); arm = 1;
      tick(); srst = 1'b0;
      tick();

      // 4-word packet, ready high: literal timing pins
      mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
      start = 1'b1; len = 4; tick();
      start = 1'b0;
      chk("t1_busy", 32'(busy), 1); chk("t1_rdpntr", 32'(rdpntr), 0);
      tick(); chk("t2_val", 32'(val), 0);
      tick(); chk("t3_val", 32'(val), 1); chk("t3_data", 32'(data), 32'hA0); chk("t3_sop", 32'(sop), 1);
      tick(); tick(); tick();
      chk("t6_eop", 32'(eop), 1); chk("t6_data", 32'(data), 32'hA3); chk("t6_busy", 32'(busy), 1);
      tick(); chk("t7_busy", 32'(busy), 0); chk("t7_val", 32'(val), 0);
      wait_done(50);

      // single-word packet and zero length
      mem[0] = 8'h5A;
      start = 1'b1; len = 1; tick(); start = 1'b0; tick(); tick();
      chk("l1_data", 32'(data), 32'h5A); chk("l1_sop", 32'(sop), 1);
      chk("l1_eop", 32'(eop), 1); chk("l1_val", 32'(val), 1);
      wait_done(50);
      start = 1'b1; len = 0; repeat (4) tick(); start = 1'b0;
      chk("l0_busy", 32'(busy), 0); chk("l0_val", 32'(val), 0);

      // full-length packets under toggling, random and burst-stall backpressure
      for (int k = 0; k < NMAX; k++) mem[k] = DW'(k);
      send(8, 1);
      send(15, 2);
      send(8, 3);

      // reset mid-packet at word 3, then a fresh 2-word packet
      rmode = 0; ready = 1'b1; b = xfer_cnt;
      start = 1'b1; len = 8; tick(); start = 1'b0;
      n = 0;
      while (xfer_cnt - b != 3 && n < 50) begin tick(); n++; end
      chk("mid_reach", 32'(xfer_cnt - b), 3);
      srst = 1'b1; tick(); srst = 1'b0;
      chk("mid_val", 32'(val), 0); chk("mid_busy", 32'(busy), 0); chk("mid_eop", 32'(eop), 0);
      repeat (3) tick();
      chk("mid_quiet", 32'(val), 0);
      send(2, 0);

      // start while busy is ignored
      b = xfer_cnt;
      start = 1'b1; len = 4; tick(); start = 1'b0; tick();
      start = 1'b1; len = 5; tick(); start = 1'b0;
      wait_done(100);
      chk("busy_ignore_words", 32'(xfer_cnt - b), 4);

      // start held across the cycle busy falls is accepted
      b = pkt_cnt;
      start = 1'b1; len = 3; tick();
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      tick(); start = 1'b0;
      wait_done(100);
      chk("b2b_pkts", 32'(pkt_cnt - b), 2);

      // randomized packets
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < NMAX; k++) mem[k] = DW'($urandom);
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
         repeat (int'($urandom_range(0, 2))) tick();
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pkt_reader.md
Name: pkt_reader

Overview:
- Read-side packet transmitter. It drains a stored packet from the sorter's single-port-read RAM and emits it as a sop/eop/val word stream, with downstream backpressure.
- It is the counterpart of the write-side input combiner. It drives the RAM read pointer, consumes the registered RAM output, and frames words with start/end markers.
- It sits between the RAM and the sorter's output port.

Parameters:
- AWIDTH, 3, RAM address width; maximum packet length is 2**AWIDTH words.
- DWIDTH, 8, data word width.

Ports:
- clk_i  in  1  single clock, rising edge.
- srst_i  in  1  synchronous active-high reset.
- start_i  in  1  request to transmit a packet; sampled only in IDLE.
- len_i  in  AWIDTH+1  packet length in words, sampled with start_i.
- rdpntr_o  out  AWIDTH  RAM read address (registered).
- q_i  in  DWIDTH  RAM read data; equals mem[rdpntr_o] one cycle after rdpntr_o is presented.
- ready_i  in  1  downstream may accept a word this cycle.
- data_o  out  DWIDTH  output word.
- sop_o  out  1  first word of packet; qualified by val_o.
- eop_o  out  1  last word of packet; qualified by val_o.
- val_o  out  1  valid for data_o, sop_o and eop_o.
- busy_o  out  1  packet in progress; start_i is ignored while high.

Behaviour:
- Reset: srst_i high at an edge forces the following, effective the next cycle regardless of state:
  - data_o=0, sop_o=0, eop_o=0, val_o=0, busy_o=0, rdpntr_o=0.
  - FSM=IDLE, skid buffer emptied.
  - Reset mid-packet aborts the packet: no eop_o is emitted and the remaining words are dropped.
- Handshake:
  - A word transfers on any cycle with val_o && ready_i.
  - While val_o && !ready_i, data_o, sop_o, eop_o and val_o are held stable.
  - val_o never drops before its transfer.
- Length rules:
  - len_i=0: start_i is ignored and the block stays IDLE.
  - len_i > 2**AWIDTH: clamped to 2**AWIDTH.
  - The effective length L is latched at the accept cycle.
- FSM:
  - IDLE: when start_i && len_i!=0, accept. Next cycle busy_o=1, rdpntr_o=0, go to READ.
  - READ: issue addresses 0..L-1 in order. rdpntr_o advances only when a fetched word is guaranteed a slot (output register or 2-entry skid buffer free). After address L-1 is issued, go to DRAIN.
  - DRAIN: wait until the word with eop_o transfers, then go to IDLE. busy_o=0 on the cycle after the eop transfer.
- Framing:
  - sop_o=1 only on word 0; eop_o=1 only on word L-1.
  - L=1 gives sop_o=eop_o=1 on the same word.
- Latency and throughput:
  - Start accepted at cycle t (ready_i held high) → rdpntr_o=0 at t+1, q_i=mem[0] at t+2, first val_o/sop_o with data_o=mem[0] at t+3.
  - Then one word per cycle; eop at t+2+L.
  - Full throughput with ready_i high is required; a stall cycle inserted by the block is a failure.
- Backpressure:
  - The RAM has 1-cycle read latency, so in-flight reads land in the skid buffer when ready_i drops.
  - Words are never lost or duplicated, and order is preserved.
- Pointer and counter widths:
  - rdpntr_o counts within AWIDTH bits and never wraps within a packet.
  - The word counter is AWIDTH+1 bits so that L=2**AWIDTH is representable.
- Back-to-back:
  - start_i is ignored while busy_o=1.
  - A start asserted on the cycle busy_o falls is accepted.
- data_o holds its last value when val_o=0; verification checks data only when val_o=1.
- No combinational path from any input to any output.

Test Plan:
- Reset, then start_i=1 with len_i=4 at t, ready_i=1, RAM={A0,A1,A2,A3} → val_o at t+3..t+6, data A0..A3, sop_o at t+3, eop_o at t+6, busy_o 1 from t+1 to t+6, 0 at t+7.
- len_i=1, RAM[0]=5A → single word 5A with sop_o=eop_o=val_o=1; len_i=0 → no output, busy_o stays 0.
- len_i=8 (AWIDTH=3), ready_i toggling 1,0,0,1,0,1... → all 8 words 00..07 delivered in order, outputs stable during stalls, exactly one sop and one eop. len_i=15 → clamped to 8 words.
- ready_i=0 from word 2 for 5 cycles, then 1 → data_o holds word 2. Words 3 and 4 come from the skid buffer with no gap, and the sequence continues uninterrupted.
- srst_i pulsed at word 3 of an 8-word packet → next cycle all outputs 0 and busy_o=0, no eop. A new start with len_i=2 then yields a correct 2-word packet.
- start_i pulsed while busy_o=1 → ignored. start_i on the cycle busy_o falls → second packet accepted, and its first word appears 3 cycles later.
